core_memory_responder: RTL

- Memory-side responder for the core's memory bus. The core drives a 15-bit address, 16-bit write data and a write enable; this block returns 16-bit read data.
- Provides a single unified instruction/data RAM with a fixed, registered read latency and write-first semantics.
- Sweeps its contents to zero after reset.
- Has a side preload port so a loader can place a program at the core's start address (9216) before or while the core runs.

---
 rtl/core_memory_responder_if.sv | 22 ++
 rtl/core_memory_responder.sv | 56 +++++
 2 files changed

// File: rtl/core_memory_responder_if.sv
// core_memory_responder_if: core memory bus plus side preload channel
//   master: core/loader side drives addrin, datain, we, load_valid, load_addr, load_data
//   slave : responder side drives dataout, ready, load_ready
interface core_memory_responder_if;
  logic [14:0] addrin;
  logic [15:0] datain;
  logic        we;
  logic [15:0] dataout;
  logic        ready;
  logic        load_valid;
  logic [14:0] load_addr;
  logic [15:0] load_data;
  logic        load_ready;
  modport master (
    output addrin, datain, we, load_valid, load_addr, load_data,
    input  dataout, ready, load_ready
  );
  modport slave (
    input  addrin, datain, we, load_valid, load_addr, load_data,
    output dataout, ready, load_ready
  );
endinterface

// File: rtl/core_memory_responder.sv
// core_memory_responder: unified core RAM with zero sweep, registered reads and preload port
//   clock  : rising-edge clock shared with the core
//   resetn : synchronous active-low reset
//   bus    : slave side of core_memory_responder_if (core read/write, ready, preload)
module core_memory_responder #(
  parameter int DEPTH          = 32768,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input logic clock,
  input logic resetn,
  core_memory_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] LIM = 16'(DEPTH);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_n;
  logic [14:0] cnt;
  logic [15:0] mem [DEPTH];
  logic [15:0] pipe [READ_LATENCY];
  logic ready_r, clearing, run, addr_ok, load_ok, core_wr, load_wr, wen;
  logic [14:0] waddr;
  logic [15:0] wdata, rdata;
  assign clearing = state == CLEAR;
  assign run      = ready_r;
  assign addr_ok  = {1'b0, bus.addrin} < LIM;
  assign load_ok  = {1'b0, bus.load_addr} < LIM;
  assign core_wr  = run & bus.we & addr_ok;
  assign load_wr  = bus.load_valid & bus.load_ready & load_ok;
  assign wen      = resetn & (clearing | core_wr | load_wr);
  // single write port: sweep, then core, then preload (load_ready already excludes we)
  assign waddr = clearing ? cnt : core_wr ? bus.addrin : bus.load_addr;
  assign wdata = clearing ? 16'h0000 : core_wr ? bus.datain : bus.load_data;
  // write-first: the word being written this edge is what the read captures
  assign rdata = !addr_ok ? 16'h0000 :
                 (wen && waddr == bus.addrin) ? wdata : mem[bus.addrin[AW-1:0]];
  assign bus.ready      = ready_r;
  assign bus.load_ready = ready_r & ~bus.we;
  assign bus.dataout    = pipe[READ_LATENCY-1];
  always_comb state_n = (clearing && {1'b0, cnt} == LIM - 16'd1) ? RUN : state;
  always_ff @(posedge clock) begin
    state   <= !resetn ? (CLEAR_ON_RESET != 0 ? CLEAR : RUN) : state_n;
    ready_r <= resetn && state_n == RUN;
    cnt     <= !resetn ? 15'd0 : clearing ? cnt + 15'd1 : cnt;
  end
  always_ff @(posedge clock)
    if (wen) mem[waddr[AW-1:0]] <= wdata;
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pipe <= '{default: '0};
    end else begin
      pipe[0] <= run ? rdata : 16'h0000;
      for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
  end
endmodule
